instruction_writeback: RTL
==========================

Name: instruction_writeback

Overview:
Writeback stage directly downstream of instruction_execute. It holds the 16 x 32-bit architectural register file and the CPSR. It commits data-operation results, 32/64-bit multiply results and condition flags, and serves two combinational read ports to decode/operand fetch. A 64-bit (long) multiply commits over two cycles and stalls upstream for one cycle.

Parameters:
CPSR_RESET, 32'h000000D3, CPSR value loaded on reset (SVC mode, IRQ/FIQ masked)
REG_RESET, 32'h00000000, value loaded into every register on reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
wb_i  input  1  writeback valid; qualifies every other *_i input this cycle
dest_i  input  4  destination register (RdLo for long multiply)
dest_hi_i  input  4  RdHi for long multiply
write_dest_do_i  input  1  commit result_i to dest_i
write_dest_m_i  input  1  commit multiply result
m_long_i  input  1  multiply is 64-bit (two-register write)
write_cpsr_i  input  1  update CPSR flags
result_i  input  32  ALU result
m_result_i  input  64  multiplier result
flags_i  input  4  N,Z,C,V for CPSR[31:28]
rd_addr_a_i  input  4  read port A address
rd_addr_b_i  input  4  read port B address
rd_a_o  output  32  read port A data
rd_b_o  output  32  read port B data
cpsr_o  output  32  current CPSR
busy_o  output  1  stage busy; upstream must hold its outputs
pc_written_o  output  1  one-cycle pulse: r15 was written in previous cycle

Behaviour:
- Reset (rst=1 at rising edge): all r0-r15 = REG_RESET, cpsr_o = CPSR_RESET, busy_o=0, pc_written_o=0, state=IDLE. Reset overrides any concurrent write, including a pending WRITE_HI; that high write is discarded.
- States: IDLE, WRITE_HI.
- IDLE, wb_i=0: no state change; pc_written_o <= 0.
- IDLE, wb_i=1:
  - write_dest_do_i=1: reg[dest_i] <= result_i. Takes priority; write_dest_m_i is ignored if both are set.
  - else write_dest_m_i=1, m_long_i=0: reg[dest_i] <= m_result_i[31:0].
  - else write_dest_m_i=1, m_long_i=1: reg[dest_i] <= m_result_i[31:0]; latch m_result_i[63:32] and dest_hi_i; busy_o <= 1; go to WRITE_HI.
  - write_cpsr_i=1: cpsr[31:28] <= flags_i; cpsr[27:0] unchanged. Independent of register writes.
- WRITE_HI: reg[latched dest_hi] <= latched high word; busy_o <= 0; return to IDLE. All *_i inputs are ignored this cycle, including wb_i.
- busy_o is registered. It is high for exactly the one cycle the stage is in WRITE_HI.
- dest_hi == dest_lo: the high word wins as the final register value.
- pc_written_o <= 1 on the edge after any commit to r15 (IDLE or WRITE_HI); otherwise 0.
- Write latency: a commit is visible in the register on the rising edge that accepts it.
- Reads: rd_a_o/rd_b_o are combinational from reg[rd_addr_*_i]. Both ports may address the same register.

Optional Feature:
WRITEBACK_BYPASS_EN
- Defined: the read ports forward data being written in the current cycle.
  - IDLE with an accepted do/m write to address X: a read of X returns the incoming low/ALU value.
  - WRITE_HI: a read of the latched dest_hi returns the latched high word.
- Undefined: reads return only registered contents. A value written this cycle is readable from the next cycle.

Test Plan:
- Reset then read all 16 addresses -> all 0; cpsr_o=32'h000000D3; busy_o=0.
- wb_i=1, write_dest_do_i=1, dest_i=3, result_i=32'hDEADBEEF -> next cycle rd_a_o(addr 3)=32'hDEADBEEF; same cycle without bypass: old value 0, with bypass: 32'hDEADBEEF.
- wb_i=1, write_dest_m_i=1, m_long_i=1, dest_i=4, dest_hi_i=5, m_result_i=64'h11112222_33334444 -> busy_o=1 for one cycle; r4=32'h33334444 after edge 1; r5=32'h11112222 after edge 2; wb_i asserted during WRITE_HI is ignored.
- write_dest_do_i=1 and write_dest_m_i=1 together, dest_i=2, result_i=1, m_result_i=64'h9 -> r2=1; write_cpsr_i=1, flags_i=4'b1010 -> cpsr_o=32'hA00000D3.
- Long multiply with dest_i=dest_hi_i=7, m_result_i=64'hAAAAAAAA_BBBBBBBB -> final r7=32'hAAAAAAAA.
- Long multiply to dest_hi_i=15, rst asserted in WRITE_HI -> r15=0, busy_o=0, pc_written_o=0; separately, do write to r15 -> pc_written_o pulses high for exactly one cycle.

Source files
------------

// File: rtl/instruction_writeback.sv
// Writeback stage: 16 x 32-bit register file plus CPSR, with a two-cycle commit
// for long multiplies. Define WRITEBACK_BYPASS_EN to forward same-cycle writes to the read ports.
module instruction_writeback #(
    parameter logic [31:0] CPSR_RESET = 32'h000000D3,
    parameter logic [31:0] REG_RESET  = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_i,
    input  logic [3:0]  dest_i,
    input  logic [3:0]  dest_hi_i,
    input  logic        write_dest_do_i,
    input  logic        write_dest_m_i,
    input  logic        m_long_i,
    input  logic        write_cpsr_i,
    input  logic [31:0] result_i,
    input  logic [63:0] m_result_i,
    input  logic [3:0]  flags_i,
    input  logic [3:0]  rd_addr_a_i,
    input  logic [3:0]  rd_addr_b_i,
    output logic [31:0] rd_a_o,
    output logic [31:0] rd_b_o,
    output logic [31:0] cpsr_o,
    output logic        busy_o,
    output logic        pc_written_o
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WRITE_HI = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] regs [16];
    logic [31:0] hi_word;
    logic [3:0]  hi_dest;

    logic        lo_we;
    logic [31:0] lo_data;
    logic        long_start;

    // Decode the low-word commit accepted in IDLE; the ALU result wins over the multiplier.
    always_comb begin
        lo_we      = 1'b0;
        lo_data    = result_i;
        long_start = 1'b0;
        if ((state == IDLE) && wb_i) begin
            if (write_dest_do_i) begin
                lo_we   = 1'b1;
                lo_data = result_i;
            end else if (write_dest_m_i) begin
                lo_we      = 1'b1;
                lo_data    = m_result_i[31:0];
                long_start = m_long_i;
            end else begin
                lo_we = 1'b0;
            end
        end else begin
            lo_we = 1'b0;
        end
    end

    // Register file, CPSR and writeback sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= REG_RESET;
            end
            cpsr_o       <= CPSR_RESET;
            busy_o       <= 1'b0;
            pc_written_o <= 1'b0;
            hi_word      <= 32'h0000_0000;
            hi_dest      <= 4'd0;
            state        <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    pc_written_o <= lo_we && (dest_i == 4'd15);
                    if (lo_we) begin
                        regs[dest_i] <= lo_data;
                    end
                    if (wb_i && write_cpsr_i) begin
                        cpsr_o[31:28] <= flags_i;
                    end
                    if (long_start) begin
                        hi_word <= m_result_i[63:32];
                        hi_dest <= dest_hi_i;
                        busy_o  <= 1'b1;
                        state   <= WRITE_HI;
                    end
                end
                WRITE_HI: begin
                    // Written after the low word, so the high word wins when both target one register.
                    regs[hi_dest] <= hi_word;
                    pc_written_o  <= (hi_dest == 4'd15);
                    busy_o        <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    pc_written_o <= 1'b0;
                    busy_o       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // Read port A, optionally forwarding the value committed on this edge.
    always_comb begin
        rd_a_o = regs[rd_addr_a_i];
`ifdef WRITEBACK_BYPASS_EN
        if (lo_we && (rd_addr_a_i == dest_i)) begin
            rd_a_o = lo_data;
        end else if ((state == WRITE_HI) && (rd_addr_a_i == hi_dest)) begin
            rd_a_o = hi_word;
        end else begin
            rd_a_o = regs[rd_addr_a_i];
        end
`endif
    end

    // Read port B, same forwarding rules as port A.
    always_comb begin
        rd_b_o = regs[rd_addr_b_i];
`ifdef WRITEBACK_BYPASS_EN
        if (lo_we && (rd_addr_b_i == dest_i)) begin
            rd_b_o = lo_data;
        end else if ((state == WRITE_HI) && (rd_addr_b_i == hi_dest)) begin
            rd_b_o = hi_word;
        end else begin
            rd_b_o = regs[rd_addr_b_i];
        end
`endif
    end

endmodule
